sprite_frame_fetch: RTL and testbench

Reads the sprite sheet on behalf of the pixel pipeline. It consumes the per-character frame selection (anim_row, anim_col, max_width) produced by the animation selector, and latches that selection once per video frame. For each scanned pixel it tests whether the pixel falls inside the character's box, forms the sprite-sheet ROM address (optionally mirrored), and returns a registered color plus an opaque flag to pattern_gen. It is the reading end of the animation selector's frame-select interface.

---
 rtl/sprite_frame_fetch_pkg.sv | 22 ++
 rtl/sprite_frame_fetch_if.sv | 27 ++
 rtl/sprite_box_test.sv | 44 ++++
 rtl/sprite_frame_fetch.sv | 117 +++++++++++
 tb/tb_sprite_frame_fetch.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sprite_frame_fetch_pkg.sv
// Shared types and defaults for the sprite fetch path and its animation selector.
package sprite_frame_fetch_pkg;

  localparam int unsigned DEF_SHEET_W   = 512;
  localparam int unsigned DEF_FRAME_H   = 48;
  localparam logic [11:0] DEF_KEY_COLOR = 12'h000;

  typedef enum logic [1:0] {
    MV_IDLE,
    MV_WALK,
    MV_RUN,
    MV_JUMP
  } movement_state_t;

  typedef enum logic [1:0] {
    ATK_NONE,
    ATK_WINDUP,
    ATK_STRIKE,
    ATK_RECOVER
  } attack_state_t;

endpackage

// File: rtl/sprite_frame_fetch_if.sv
// Sprite ROM read port plus the registered pixel result handed to pattern_gen.
interface sprite_frame_fetch_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned PIX_W  = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic [PIX_W-1:0]  pix_color;
  logic              pix_opaque;
  logic              pix_valid;

  modport master (
    output rom_addr,
    input  rom_data,
    output pix_color,
    output pix_opaque,
    output pix_valid
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  pix_color,
    input  pix_opaque,
    input  pix_valid
  );
endinterface

// File: rtl/sprite_box_test.sv
// Combinational S1 math: box hit test and sprite-sheet address (mirror under SPRITE_MIRROR_EN).
module sprite_box_test
  import sprite_frame_fetch_pkg::*;
#(
  parameter int unsigned SHEET_W = DEF_SHEET_W,
  parameter int unsigned FRAME_H = DEF_FRAME_H,
  parameter int unsigned ADDR_W  = 18
) (
`ifdef SPRITE_MIRROR_EN
  input  logic              i_mirror,
`endif
  input  logic [9:0]        i_scan_x,
  input  logic [9:0]        i_scan_y,
  input  logic [9:0]        i_sx,
  input  logic [9:0]        i_sy,
  input  logic [10:0]       i_arow,
  input  logic [10:0]       i_acol,
  input  logic [5:0]        i_width,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_addr
);

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_width;
  logic [10:0] w_col;

  // Zero-extended 11-bit differences: bit 10 set means the scan pixel is left of / above the box.
  assign w_dx    = {1'b0, i_scan_x} - {1'b0, i_sx};
  assign w_dy    = {1'b0, i_scan_y} - {1'b0, i_sy};
  assign w_width = {5'b0, i_width};

  assign o_hit = ~w_dx[10] & ~w_dy[10] & (w_dx < w_width) & (w_dy < 11'(FRAME_H));

`ifdef SPRITE_MIRROR_EN
  assign w_col = i_mirror ? (w_width - 11'd1 - w_dx) : w_dx;
`else
  assign w_col = w_dx;
`endif

  assign o_addr = (ADDR_W'(i_arow) + ADDR_W'(w_dy)) * ADDR_W'(SHEET_W)
                + ADDR_W'(i_acol) + ADDR_W'(w_col);

endmodule

// File: rtl/sprite_frame_fetch.sv
// Per-frame shadow of the animation selection and 3-stage sprite ROM fetch pipeline.
// Horizontal mirroring is built only when SPRITE_MIRROR_EN is defined.
module sprite_frame_fetch
  import sprite_frame_fetch_pkg::*;
#(
  parameter int unsigned SHEET_W   = DEF_SHEET_W,
  parameter int unsigned FRAME_H   = DEF_FRAME_H,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned PIX_W     = 12,
  parameter logic [PIX_W-1:0] KEY_COLOR = PIX_W'(DEF_KEY_COLOR)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [10:0] anim_row,
  input  logic [10:0] anim_col,
  input  logic [5:0]  max_width,
  input  logic        facing_left,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [9:0]  scan_x,
  input  logic [9:0]  scan_y,
  input  logic        scan_valid,
  sprite_frame_fetch_if.master bus
);

  logic [10:0]       r_arow;
  logic [10:0]       r_acol;
  logic [5:0]        r_width;
  logic [9:0]        r_sx;
  logic [9:0]        r_sy;
  logic              w_hit;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit1, r_vld1;
  logic              r_hit2, r_vld2;
  logic [PIX_W-1:0]  r_pix_color;
  logic              r_pix_opaque;
  logic              r_pix_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arow  <= '0;
      r_acol  <= '0;
      r_width <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
    end else if (frame_start) begin
      r_arow  <= anim_row;
      r_acol  <= anim_col;
      r_width <= max_width;
      r_sx    <= sprite_x;
      r_sy    <= sprite_y;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic r_mirror;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_mirror <= 1'b0;
    else if (frame_start) r_mirror <= facing_left;
  end
`else
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
`endif

  sprite_box_test #(
    .SHEET_W (SHEET_W),
    .FRAME_H (FRAME_H),
    .ADDR_W  (ADDR_W)
  ) u_box (
`ifdef SPRITE_MIRROR_EN
    .i_mirror (r_mirror),
`endif
    .i_scan_x (scan_x),
    .i_scan_y (scan_y),
    .i_sx     (r_sx),
    .i_sy     (r_sy),
    .i_arow   (r_arow),
    .i_acol   (r_acol),
    .i_width  (r_width),
    .o_hit    (w_hit),
    .o_addr   (w_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr   <= '0;
      r_hit1       <= 1'b0;
      r_vld1       <= 1'b0;
      r_hit2       <= 1'b0;
      r_vld2       <= 1'b0;
      r_pix_color  <= '0;
      r_pix_opaque <= 1'b0;
      r_pix_valid  <= 1'b0;
    end else begin
      if (scan_valid) r_rom_addr <= w_addr;
      r_vld1       <= scan_valid;
      r_hit1       <= scan_valid & w_hit;
      r_vld2       <= r_vld1;
      r_hit2       <= r_hit1;
      // Color holds between pixels so idle ROM reads never reach the output.
      if (r_vld2) r_pix_color <= bus.rom_data;
      r_pix_opaque <= r_hit2 & (bus.rom_data != KEY_COLOR);
      r_pix_valid  <= r_vld2;
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.pix_color  = r_pix_color;
  assign bus.pix_opaque = r_pix_opaque;
  assign bus.pix_valid  = r_pix_valid;

endmodule

// File: tb/tb_sprite_frame_fetch.sv
// Directed bench for sprite_frame_fetch; mirror expectations follow SPRITE_MIRROR_EN.
module tb_sprite_frame_fetch;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic [10:0] anim_row;
  logic [10:0] anim_col;
  logic [5:0]  max_width;
  logic        facing_left;
  logic [9:0]  sprite_x, sprite_y;
  logic [9:0]  scan_x, scan_y;
  logic        scan_valid;

  int unsigned n_cmp;
  int unsigned n_fail;

  sprite_frame_fetch_if #(.ADDR_W(18), .PIX_W(12)) bus ();

  sprite_frame_fetch #(
    .SHEET_W   (512),
    .FRAME_H   (48),
    .ADDR_W    (18),
    .PIX_W     (12),
    .KEY_COLOR (12'h000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .anim_row    (anim_row),
    .anim_col    (anim_col),
    .max_width   (max_width),
    .facing_left (facing_left),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_valid  (scan_valid),
    .bus         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model with a few hand-placed texels.
  function automatic logic [11:0] rom_fn(input logic [17:0] a);
    if (a == 18'd1633)      return 12'hF80;
    else if (a == 18'd1634) return 12'h000;
    else                    return 12'h123;
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int row, input int col, input int w,
                            input int sx, input int sy, input logic face);
    anim_row    = 11'(row);
    anim_col    = 11'(col);
    max_width   = 6'(w);
    sprite_x    = 10'(sx);
    sprite_y    = 10'(sy);
    facing_left = face;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pixel(input string tag, input int x, input int y, input int exp_addr,
                       input logic exp_opq, input logic [11:0] exp_col);
    scan_x     = 10'(x);
    scan_y     = 10'(y);
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    chk({tag, ".addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    chk({tag, ".v1"}, 32'(bus.pix_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v2"}, 32'(bus.pix_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v3"}, 32'(bus.pix_valid), 32'd1);
    chk({tag, ".opq"}, 32'(bus.pix_opaque), 32'(exp_opq));
    chk({tag, ".col"}, 32'(bus.pix_color), 32'(exp_col));
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    anim_row    = '0;
    anim_col    = '0;
    max_width   = '0;
    facing_left = 1'b0;
    sprite_x    = '0;
    sprite_y    = '0;
    scan_x      = '0;
    scan_y      = '0;
    scan_valid  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.addr", 32'(bus.rom_addr), 32'd0);
    chk("rst.col", 32'(bus.pix_color), 32'd0);
    chk("rst.opq", 32'(bus.pix_opaque), 32'd0);
    chk("rst.vld", 32'(bus.pix_valid), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // No frame latched yet: width 0, shadows 0 -> 203*512+105.
    pixel("prefr", 105, 203, 104041, 1'b0, 12'h123);

    load_frame(0, 92, 46, 100, 200, 1'b0);
    pixel("hit", 105, 203, 1633, 1'b1, 12'hF80);
    pixel("key", 106, 203, 1634, 1'b0, 12'h000);
    pixel("clipR", 146, 200, 138, 1'b0, 12'h123);
    pixel("clipB", 100, 248, 24668, 1'b0, 12'h123);
    pixel("corner", 145, 247, 24201, 1'b1, 12'h123);
    pixel("borrow", 99, 200, 2139, 1'b0, 12'h123);

    load_frame(0, 92, 46, 100, 200, 1'b1);
`ifdef SPRITE_MIRROR_EN
    pixel("mirror", 105, 203, 1668, 1'b1, 12'h123);
`else
    pixel("mirror", 105, 203, 1633, 1'b1, 12'hF80);
`endif

    // Selection change without frame_start must not take effect.
    load_frame(0, 92, 46, 100, 200, 1'b0);
    anim_col   = 11'd138;
    scan_x     = 10'd105;
    scan_y     = 10'd203;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    chk("latch.mid", 32'(bus.rom_addr), 32'd1633);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("latch.coinc", 32'(bus.rom_addr), 32'd1633);
    @(posedge clk); #1;
    scan_valid = 1'b0;
    chk("latch.next", 32'(bus.rom_addr), 32'd1679);
    repeat (4) @(posedge clk);
    #1;

    load_frame(0, 92, 0, 100, 200, 1'b0);
    pixel("w0.a", 100, 200, 92, 1'b0, 12'h123);
    pixel("w0.b", 105, 203, 1633, 1'b0, 12'hF80);
    pixel("w0.c", 120, 220, 10352, 1'b0, 12'h123);

    // Three pixels in flight, then asynchronous reset mid-cycle.
    load_frame(0, 92, 46, 100, 200, 1'b0);
    scan_y     = 10'd203;
    scan_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scan_x = 10'(105 + i);
      @(posedge clk); #1;
    end
    scan_valid = 1'b0;
    chk("fly.vld", 32'(bus.pix_valid), 32'd1);
    chk("fly.opq", 32'(bus.pix_opaque), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.vld", 32'(bus.pix_valid), 32'd0);
    chk("arst.opq", 32'(bus.pix_opaque), 32'd0);
    chk("arst.addr", 32'(bus.rom_addr), 32'd0);
    chk("arst.col", 32'(bus.pix_color), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post.vld", 32'(bus.pix_valid), 32'd0);
      chk("post.opq", 32'(bus.pix_opaque), 32'd0);
    end
    pixel("post.shadow", 105, 203, 104041, 1'b0, 12'h123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
